// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a synchronous FIFO (1-cycle read latency) and packs
// PACK_RATIO words into one wide valid/ready beat; supports flush and err.
// Ports: clk, rst (sync, high); fifo_data_out/fifo_empty/fifo_underflow in,
// fifo_rd_en out; flush in; out_data/out_count/out_valid out, out_ready in;
// err out (sticky).
module fifo_rd_packer #(
  parameter int FIFO_WIDTH = 16,
  parameter int PACK_RATIO = 4,
  parameter int CNT_W      = $clog2(PACK_RATIO+1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FIFO_WIDTH-1:0]            fifo_data_out,
  input  logic                             fifo_empty,
  input  logic                             fifo_underflow,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [FIFO_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [CNT_W-1:0]                 out_count,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             err
);
  localparam int OW = FIFO_WIDTH*PACK_RATIO;
  localparam logic [CNT_W:0]   RATIO_X = (CNT_W+1)'(PACK_RATIO);
  localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(PACK_RATIO);

  logic [OW-1:0]    acc_q, acc_d, acc_mask;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             rd_pending_q, rd_pending_d;
  logic             flush_req_q, flush_req_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [CNT_W:0]   inflight;
  logic             rd_en, complete, xfer;

  always_comb begin
    // Words already held plus the one still in flight; one extra bit so
    // the sum never wraps.
    inflight = {1'b0, acc_cnt_q} + {{CNT_W{1'b0}}, rd_pending_q};
    rd_en    = !rst && !fifo_empty && !flush_req_q && (inflight < RATIO_X);
    // A flushed partial word waits for any in-flight read to land first.
    complete = (acc_cnt_q == RATIO_C) ||
               (flush_req_q && !rd_pending_q && (acc_cnt_q != '0));
    xfer     = complete && (!out_valid_q || out_ready);

    acc_mask = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (CNT_W'(i) < acc_cnt_q) acc_mask[i*FIFO_WIDTH +: FIFO_WIDTH] = '1;
    end

    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    rd_pending_d = rd_en;
    flush_req_d  = flush_req_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q;
    err_d        = err_q | (rd_pending_q & fifo_underflow) | (rd_en & fifo_empty);

    if (rd_pending_q) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (acc_cnt_q == CNT_W'(i)) acc_d[i*FIFO_WIDTH +: FIFO_WIDTH] = fifo_data_out;
      end
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    if (xfer) begin
      // Stale slots from an earlier word are zeroed on the way out.
      out_data_d  = acc_q & acc_mask;
      out_count_d = acc_cnt_q;
      out_valid_d = 1'b1;
      acc_cnt_d   = '0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (xfer) begin
      flush_req_d = 1'b0;
    end else if (flush) begin
      flush_req_d = 1'b1;
    end else if (flush_req_q && !rd_pending_q && (acc_cnt_q == '0)) begin
      flush_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      rd_pending_q <= 1'b0;
      flush_req_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      rd_pending_q <= rd_pending_d;
      flush_req_q  <= flush_req_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign out_data   = out_data_q;
  assign out_count  = out_count_q;
  assign out_valid  = out_valid_q;
  assign err        = err_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed vector table plus hand sequences for
// fifo_rd_packer, with a behavioural FIFO model feeding the DUT.
module tb_fifo_rd_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fifo_data_out = '0;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic        flush;
  logic [63:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  fifo_rd_packer dut (
    .clk(clk), .rst(rst),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
    .flush(flush), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [63:0] beat_d [0:63];
  logic [2:0]  beat_c [0:63];
  int nbeats = 0;

  always @(posedge clk) begin
    if (out_valid && out_ready && nbeats < 64) begin
      beat_d[nbeats] <= out_data;
      beat_c[nbeats] <= out_count;
      nbeats <= nbeats + 1;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(logic [15:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int               nw;
    logic [7:0][15:0] w;
    bit               fl;
    int               exp_n;
    logic [1:0][63:0] d;
    logic [1:0][2:0]  c;
  } vec_t;

  vec_t vec [5];

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int bad;
    logic [7:0] rd_pat;
    logic [7:0] v_pat;
    logic [63:0] seen;

    vec[0].nw = 5; vec[0].fl = 1; vec[0].exp_n = 2;
    vec[0].w = 128'h0000_0000_0000_00A4_00A3_00A2_00A1_00A0;
    vec[0].d = {64'h0000_0000_0000_00A4, 64'h00A3_00A2_00A1_00A0};
    vec[0].c = {3'd1, 3'd4};
    vec[1].nw = 2; vec[1].fl = 1; vec[1].exp_n = 1;
    vec[1].w = 128'h0000_0000_0000_0000_0000_0000_2222_1111;
    vec[1].d = {64'h0, 64'h0000_0000_2222_1111};
    vec[1].c = {3'd0, 3'd2};
    vec[2].nw = 0; vec[2].fl = 1; vec[2].exp_n = 0;
    vec[2].w = '0; vec[2].d = '0; vec[2].c = '0;
    vec[3].nw = 8; vec[3].fl = 0; vec[3].exp_n = 2;
    vec[3].w = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    vec[3].d = {64'h0107_0106_0105_0104, 64'h0103_0102_0101_0100};
    vec[3].c = {3'd4, 3'd4};
    vec[4].nw = 7; vec[4].fl = 1; vec[4].exp_n = 2;
    vec[4].w = 128'h0000_5007_5006_5005_5004_5003_5002_5001;
    vec[4].d = {64'h0000_5007_5006_5005, 64'h5004_5003_5002_5001};
    vec[4].c = {3'd3, 3'd4};

    rst = 1; flush = 0; out_ready = 1; fifo_underflow = 0;
    cyc(3);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    @(negedge clk);
    rst = 0;

    // basic pack with timing pattern
    base = nbeats;
    for (int k = 1; k <= 4; k++) push(16'(k));
    rd_pat = '0; v_pat = '0; seen = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      rd_pat[k] = fifo_rd_en;
      v_pat[k] = out_valid;
      if (k == 6) seen = out_data;
      @(negedge clk);
    end
    chk("basic_rd_en_pattern", rd_pat, 8'b0000_1111);
    chk("basic_valid_pattern", v_pat, 8'b0100_0000);
    chk("basic_data", seen, 64'h0004_0003_0002_0001);
    chk("basic_nbeats", nbeats - base, 1);
    chk("basic_count", beat_c[base], 4);

    // table vectors
    for (int v = 0; v < 5; v++) begin
      base = nbeats;
      for (int j = 0; j < vec[v].nw; j++) push(vec[v].w[j]);
      cyc(20);
      if (vec[v].fl) begin
        flush = 1;
        cyc(1);
        flush = 0;
        cyc(10);
      end
      chk($sformatf("vec%0d_nbeats", v), nbeats - base, vec[v].exp_n);
      for (int j = 0; j < vec[v].exp_n; j++) begin
        chk($sformatf("vec%0d_beat%0d_data", v, j), beat_d[base+j], vec[v].d[j]);
        chk($sformatf("vec%0d_beat%0d_count", v, j), beat_c[base+j], vec[v].c[j]);
      end
    end

    // backpressure
    out_ready = 0;
    for (int k = 0; k < 8; k++) push(16'h0010 + 16'(k));
    cyc(12);
    #1;
    chk("bp_valid", out_valid, 1);
    chk("bp_data_early", out_data, 64'h0013_0012_0011_0010);
    cyc(10);
    #1;
    chk("bp_data_late", out_data, 64'h0013_0012_0011_0010);
    chk("bp_count", out_count, 4);
    chk("bp_rd_en_stall", fifo_rd_en, 0);
    chk("bp_fifo_drained", fifo_empty, 1);
    @(negedge clk);
    base = nbeats;
    out_ready = 1;
    cyc(12);
    chk("bp_nbeats", nbeats - base, 2);
    chk("bp_beat0", beat_d[base], 64'h0013_0012_0011_0010);
    chk("bp_beat1", beat_d[base+1], 64'h0017_0016_0015_0014);

    // flush on the cycle of the third read issue
    base = nbeats;
    push(16'h00AA); push(16'h00BB); push(16'h00CC);
    cyc(2);
    flush = 1;
    #1;
    chk("fl_third_issue", fifo_rd_en, 1);
    @(negedge clk);
    flush = 0;
    cyc(10);
    chk("fl_nbeats", nbeats - base, 1);
    chk("fl_data", beat_d[base], 64'h0000_00CC_00BB_00AA);
    chk("fl_count", beat_c[base], 3);

    // empty stall mid-word
    base = nbeats;
    push(16'h0201); push(16'h0202);
    cyc(4);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (fifo_rd_en || out_valid) bad++;
      @(negedge clk);
    end
    chk("stall_quiet_cycles_bad", bad, 0);
    push(16'h0203); push(16'h0204);
    cyc(10);
    chk("stall_nbeats", nbeats - base, 1);
    chk("stall_data", beat_d[base], 64'h0204_0203_0202_0201);

    // reset with a read in flight
    base = nbeats;
    for (int k = 1; k <= 4; k++) push(16'h0300 + 16'(k));
    cyc(3);
    rst = 1;
    #1;
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_err", err, 0);
    for (int k = 5; k <= 7; k++) push(16'h0300 + 16'(k));
    cyc(15);
    chk("mid_rst_nbeats", nbeats - base, 1);
    chk("mid_rst_data_after", beat_d[base], 64'h0307_0306_0305_0304);

    // underflow in the cycle after a read
    chk("err_clear_before", err, 0);
    base = nbeats;
    for (int k = 1; k <= 4; k++) push(16'h0400 + 16'(k));
    @(negedge clk);
    fifo_underflow = 1;
    @(negedge clk);
    fifo_underflow = 0;
    #1;
    chk("err_set", err, 1);
    cyc(10);
    chk("err_sticky", err, 1);
    chk("err_data", beat_d[base], 64'h0404_0403_0402_0401);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("err_cleared_by_rst", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
